// File: rtl/rca_accumulator_32bits.sv
// rca_accumulator_32bits: valid/ready accumulator over a 32-bit ripple-carry adder; define ACC_SATURATE_EN to clamp the sum on carry-out
module rca_32bits (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] c;
  assign c[0] = cin;
  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_fa
      assign sum[i]   = in1[i] ^ in2[i] ^ c[i];
      assign c[i + 1] = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
    end
  endgenerate
  assign cout = c[32];
endmodule

module rca_accumulator_32bits #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_cin,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_cout,
  output logic        out_ovf,
  output logic [7:0]  out_count
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  state_t state, next;
  logic [31:0] acc, op, sum, acc_nxt;
  logic        cin_r, last_r, cout, capture;
  logic [3:0]  cnt;
  rca_32bits u_rca (.in1(acc), .in2(op), .cin(cin_r), .sum(sum), .cout(cout));
`ifdef ACC_SATURATE_EN
  assign acc_nxt = cout ? 32'hFFFF_FFFF : sum;
`else
  assign acc_nxt = sum;
`endif
  assign capture   = (state == SETTLE) && (cnt == 4'd0);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  always_comb begin
    next = state;
    next = (state == IDLE && in_valid) ? SETTLE :
           capture ? (last_r ? DONE : IDLE) :
           (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      op        <= '0;
      cin_r     <= 1'b0;
      last_r    <= 1'b0;
      cnt       <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        op     <= in_data;
        cin_r  <= in_cin;
        last_r <= in_last;
        cnt    <= 4'(SETTLE_CYCLES - 1);
      end
      if (state == SETTLE) cnt <= cnt - 4'd1;
      if (capture) begin
        acc       <= acc_nxt;
        out_cout  <= cout;
        out_ovf   <= out_ovf | cout;
        out_count <= out_count + 8'(out_count != 8'hFF);
      end
      if (state == DONE && out_ready) begin
        acc       <= '0;
        out_cout  <= 1'b0;
        out_ovf   <= 1'b0;
        out_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rca_accumulator_32bits.sv
// tb_rca_accumulator_32bits: directed bench for the accumulator with SETTLE_CYCLES = 2
module tb_rca_accumulator_32bits;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_cin = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic [7:0]  out_count;
  int tests = 0;
  int fails = 0;

  rca_accumulator_32bits #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_cin(in_cin), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Returns at the falling edge right after the accepting rising edge.
  task automatic send(input logic [31:0] d, input logic c, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_cin = c; in_last = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!out_valid) begin
      fails++;
      $display("FAIL done_timeout: out_valid=%0b, required 1", out_valid);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if ({out_valid, in_ready, out_sum, out_cout, out_ovf, out_count} !== {1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL consume_clear: valid=%0b ready=%0b sum=%0d cout=%0b ovf=%0b count=%0d, required 0 1 0 0 0 0",
               out_valid, in_ready, out_sum, out_cout, out_ovf, out_count);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, out_sum, out_cout, out_ovf, out_count} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL reset_state: ready=%0b valid=%0b sum=%0d cout=%0b ovf=%0b count=%0d, required 1 0 0 0 0 0",
               in_ready, out_valid, out_sum, out_cout, out_ovf, out_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_latency();
    send(32'd1117, 1'b0, 1'b0);
    send(32'd211132, 1'b0, 1'b1);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_early: out_valid=%0b one cycle after accept, required 0", out_valid);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL latency_exact: out_valid=%0b two cycles after accept, required 1", out_valid);
    end
    tests++;
    if ({out_sum, out_cout, out_ovf, out_count} !== {32'd212249, 1'b0, 1'b0, 8'd2}) begin
      fails++;
      $display("FAIL basic_sum: sum=%0d cout=%0b ovf=%0b count=%0d, required 212249 0 0 2",
               out_sum, out_cout, out_ovf, out_count);
    end
    consume();
  endtask

  task automatic test_carry_in();
    send(32'd1155123, 1'b1, 1'b0);
    send(32'd10000000, 1'b0, 1'b1);
    wait_done();
    tests++;
    if ({out_sum, out_count} !== {32'd11155124, 8'd2}) begin
      fails++;
      $display("FAIL carry_in: sum=%0d count=%0d, required 11155124 2", out_sum, out_count);
    end
    consume();
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
`ifdef ACC_SATURATE_EN
    exp = 32'hFFFF_FFFF;
`else
    exp = 32'd0;
`endif
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'd1, 1'b0, 1'b1);
    wait_done();
    tests++;
    if ({out_sum, out_cout, out_ovf, out_count} !== {exp, 1'b1, 1'b1, 8'd2}) begin
      fails++;
      $display("FAIL wrap: sum=%h cout=%0b ovf=%0b count=%0d, required %h 1 1 2",
               out_sum, out_cout, out_ovf, out_count, exp);
    end
    consume();
  endtask

  task automatic test_backpressure();
    send(32'd1, 1'b1, 1'b1);
    wait_done();
    for (int k = 0; k < 5; k++) begin
      tests++;
      if ({out_valid, in_ready, out_sum} !== {1'b1, 1'b0, 32'd2}) begin
        fails++;
        $display("FAIL backpressure_hold[%0d]: valid=%0b ready=%0b sum=%0d, required 1 0 2",
                 k, out_valid, in_ready, out_sum);
      end
      in_valid = 1'b1; in_data = 32'd99;
      @(negedge clk);
    end
    in_valid = 1'b0;
    consume();
  endtask

  task automatic test_reset_mid_settle();
    send(32'd1000000, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if ({in_ready, out_sum, out_count} !== {1'b1, 32'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset_mid_settle: ready=%0b sum=%0d count=%0d, required 1 0 0", in_ready, out_sum, out_count);
    end
    @(negedge clk);
    send(32'd2000000, 1'b0, 1'b1);
    wait_done();
    tests++;
    if ({out_sum, out_count} !== {32'd2000000, 8'd1}) begin
      fails++;
      $display("FAIL after_reset_batch: sum=%0d count=%0d, required 2000000 1", out_sum, out_count);
    end
    consume();
  endtask

  task automatic test_ovf_sticky();
    logic [31:0] exp;
    logic        ec;
`ifdef ACC_SATURATE_EN
    exp = 32'hFFFF_FFFF; ec = 1'b1;
`else
    exp = 32'd5; ec = 1'b0;
`endif
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'd1, 1'b0, 1'b0);
    send(32'd5, 1'b0, 1'b1);
    wait_done();
    tests++;
    if ({out_sum, out_cout, out_ovf, out_count} !== {exp, ec, 1'b1, 8'd3}) begin
      fails++;
      $display("FAIL ovf_sticky: sum=%h cout=%0b ovf=%0b count=%0d, required %h %0b 1 3",
               out_sum, out_cout, out_ovf, out_count, exp, ec);
    end
    consume();
  endtask

  task automatic test_count_saturate();
    for (int k = 0; k < 256; k++) send(32'd1, 1'b0, 1'b0);
    send(32'd3, 1'b0, 1'b1);
    wait_done();
    tests++;
    if ({out_sum, out_count} !== {32'd259, 8'd255}) begin
      fails++;
      $display("FAIL count_saturate: sum=%0d count=%0d, required 259 255", out_sum, out_count);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_carry_in();
    test_wrap();
    test_backpressure();
    test_reset_mid_settle();
    test_ovf_sticky();
    test_count_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
